// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 7-segment digit scanner.
// Each digit gets an ACTIVE slot of REFRESH_DIV cycles and then a GUARD slot of
// GUARD_CYCLES cycles with every digit dark. A new display value is captured into
// a pending register and moves into the shadow register only at the frame
// boundary, so a frame never shows a mix of old and new digits.
// Optional feature: define SEG7_LZ_SUPPRESS_EN to darken leading zero digits.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    load_ack
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        ACTIVE = 1'b0,
        GUARD  = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_flag;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [NUM_DIGITS-1:0]   lz_dark;

    // Frame boundary: last GUARD cycle of the last digit while scanning runs.
    assign boundary = enable && (state == GUARD) &&
                      (cnt == CNT_W'(GUARD_CYCLES - 1)) &&
                      (idx == IDX_W'(NUM_DIGITS - 1));

    // Next-state logic for slot timing; everything holds while enable is low.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        if (enable) begin
            case (state)
                ACTIVE: begin
                    if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                        state_next = GUARD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                GUARD: begin
                    if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
                        state_next = ACTIVE;
                        cnt_next   = '0;
                        idx_next   = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = GUARD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State registers plus pending/shadow value pipeline; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset) begin
            state     <= GUARD;
            cnt       <= '0;
            idx       <= IDX_W'(NUM_DIGITS - 1);
            shadow    <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            if (boundary) begin
                // A load in the boundary cycle is newer than anything pending.
                if (load) begin
                    shadow <= value;
                end else if (pend_flag) begin
                    shadow <= pending;
                end
                pend_flag <= 1'b0;
            end else if (load) begin
                pending   <= value;
                pend_flag <= 1'b1;
            end
        end
    end

    // Digit selection: current shadow nibble and one-hot enable for idx.
    always_comb begin
        nibble = 4'h0;
        onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble    = shadow[4*i +: 4];
                onehot[i] = 1'b1;
            end
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    // Leading-zero suppression: digit i>0 is dark if it and all higher digits are zero.
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        lz_dark     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero && (shadow[4*i +: 4] == 4'h0);
            lz_dark[i]  = higher_zero && (i != 0);
        end
    end
`else
    // Every unmasked digit is shown, leading zeros included.
    assign lz_dark = '0;
`endif

    // Outputs: digits lit only in ACTIVE with scanning enabled; ack only in a live boundary.
    always_comb begin
        digit_en = '0;
        if ((state == ACTIVE) && enable) begin
            digit_en = onehot & ~blank_mask & ~lz_dark;
        end
        load_ack = boundary && !reset && (load || pend_flag);
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed testbench for seg7_scan_ctrl with
// NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2 (24-cycle frame).
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;
    localparam int G = 2;
    localparam int SLOT  = R + G;
    localparam int FRAME = N * SLOT;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [4*N-1:0] value;
    logic          load;
    logic [N-1:0]  blank_mask;
    logic [3:0]    nibble;
    logic [N-1:0]  digit_en;
    logic          load_ack;

    int n_pass  = 0;
    int n_total = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .GUARD_CYCLES(G)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .value     (value),
        .load      (load),
        .blank_mask(blank_mask),
        .nibble    (nibble),
        .digit_en  (digit_en),
        .load_ack  (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected enable for a slot position, from the bench's own view of the shadow value.
    function automatic logic [N-1:0] model_en(int p, logic [4*N-1:0] shadow, logic [N-1:0] mask);
        int  s;
        logic dark;
        s    = p / SLOT;
        dark = mask[s];
`ifdef SEG7_LZ_SUPPRESS_EN
        if (s > 0 && (shadow >> (4 * s)) == '0) dark = 1'b1;
`endif
        if ((p % SLOT) < R && !dark) return N'(1) << s;
        return '0;
    endfunction

    function automatic logic [3:0] model_nib(int p, logic [4*N-1:0] shadow);
        logic [4*N-1:0] sh;
        sh = shadow >> (4 * (p / SLOT));
        return sh[3:0];
    endfunction

    task automatic cmp(string name, int p, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, p, act, exp);
        else n_pass++;
    endtask

    // Runs one full frame starting at the first ACTIVE cycle of digit 0.
    // Up to two loads are pulsed at positions l1/l2 (-1 = none).
    task automatic run_frame(logic [4*N-1:0] shadow, int l1, logic [4*N-1:0] v1,
                             int l2, logic [4*N-1:0] v2, logic ack_end);
        for (int p = 0; p < FRAME; p++) begin
            load  = (p == l1) || (p == l2);
            value = (p == l2) ? v2 : v1;
            #1;
            cmp("digit_en", p, 32'(digit_en), 32'(model_en(p, shadow, blank_mask)));
            cmp("nibble",   p, 32'(nibble),   32'(model_nib(p, shadow)));
            cmp("load_ack", p, 32'(load_ack), 32'((p == FRAME - 1) ? ack_end : 1'b0));
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b0; value = '0; blank_mask = '0;
        tick();
        tick();
        cmp("rst_digit_en", 0, 32'(digit_en), 0);
        cmp("rst_nibble",   0, 32'(nibble),   0);
        cmp("rst_load_ack", 0, 32'(load_ack), 0);
        // First cycle after reset: GUARD count 0, load 0x1234 here.
        reset = 1'b0; load = 1'b1; value = 16'h1234;
        #1;
        cmp("post_rst_ack0", 0, 32'(load_ack), 0);
        cmp("post_rst_en0",  0, 32'(digit_en), 0);
        tick();
        load = 1'b0;
        #1;
        // GUARD_CYCLES after reset: first frame boundary.
        cmp("first_boundary_ack", 1, 32'(load_ack), 1);
        cmp("first_boundary_en",  1, 32'(digit_en), 0);
        cmp("first_boundary_nib", 1, 32'(nibble),   0);
        tick();
    endtask

    task automatic test_first_frame();
        run_frame(16'h1234, -1, '0, -1, '0, 1'b0);
    endtask

    task automatic test_midframe_load();
        run_frame(16'h1234, 7, 16'hABCD, -1, '0, 1'b1);
        run_frame(16'hABCD, -1, '0, -1, '0, 1'b0);
    endtask

    task automatic test_double_load();
        run_frame(16'hABCD, 3, 16'h1111, 15, 16'h2222, 1'b1);
        run_frame(16'h2222, -1, '0, -1, '0, 1'b0);
    endtask

    task automatic test_boundary_load();
        run_frame(16'h2222, FRAME - 1, 16'h5678, -1, '0, 1'b1);
        run_frame(16'h5678, -1, '0, -1, '0, 1'b0);
    endtask

    task automatic test_blank();
        blank_mask = 4'b0100;
        run_frame(16'h5678, -1, '0, -1, '0, 1'b0);
        blank_mask = '0;
    endtask

    // Enable low for 10 cycles from cycle 2: frame stretches to 34, load held in pending.
    task automatic test_enable_stretch();
        int p;
        for (int c = 0; c < FRAME + 10; c++) begin
            enable = !(c >= 2 && c < 12);
            load   = (c == 5);
            value  = 16'h9ABC;
            p      = (c < 2) ? c : (c < 12) ? 2 : c - 10;
            #1;
            cmp("stretch_en",  c, 32'(digit_en), enable ? 32'(model_en(p, 16'h5678, '0)) : 0);
            cmp("stretch_nib", c, 32'(nibble),   32'(model_nib(p, 16'h5678)));
            cmp("stretch_ack", c, 32'(load_ack), (c == FRAME + 9) ? 1 : 0);
            tick();
        end
        enable = 1'b1; load = 1'b0;
        run_frame(16'h9ABC, -1, '0, -1, '0, 1'b0);
    endtask

`ifdef SEG7_LZ_SUPPRESS_EN
    task automatic test_lz_suppress();
        run_frame(16'h9ABC, FRAME - 1, 16'h0040, -1, '0, 1'b1);
        run_frame(16'h0040, FRAME - 1, 16'h0000, -1, '0, 1'b1);
        run_frame(16'h0000, FRAME - 1, 16'h9ABC, -1, '0, 1'b1);
    endtask
`endif

    // Reset in the middle of digit 0's ACTIVE slot, with a load pending and one in flight.
    task automatic test_reset_mid();
        load = 1'b1; value = 16'h7777;
        tick();
        reset = 1'b1; load = 1'b1; value = 16'hFFFF;
        tick();
        cmp("midrst_en",  0, 32'(digit_en), 0);
        cmp("midrst_nib", 0, 32'(nibble),   0);
        cmp("midrst_ack", 0, 32'(load_ack), 0);
        reset = 1'b0; load = 1'b0;
        #1;
        cmp("midrst_ackA", 1, 32'(load_ack), 0);
        tick();
        #1;
        cmp("midrst_boundary_ack", 2, 32'(load_ack), 0);
        cmp("midrst_boundary_nib", 2, 32'(nibble),   0);
        tick();
        run_frame(16'h0000, -1, '0, -1, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_midframe_load();
        test_double_load();
        test_boundary_load();
        test_blank();
        test_enable_stretch();
`ifdef SEG7_LZ_SUPPRESS_EN
        test_lz_suppress();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 1000: ACTIVE slot length in clk cycles, minimum 1.
REQ-003 SHALL have parameter GUARD_CYCLES, default 16: all-digits-off dead time between slots in clk cycles, minimum 1.
REQ-004 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1: high = scanning runs; low = scan frozen, display dark.
REQ-007 SHALL have port value  input  4*NUM_DIGITS: hex digits, digit i = value[4i+3:4i], digit 0 least significant.
REQ-008 SHALL have port load  input  1: one-cycle request to capture value.
REQ-009 SHALL have port blank_mask  input  NUM_DIGITS: bit i high forces digit i dark in its slot.
REQ-010 SHALL have port nibble  output  4: hex code of the current digit, for the 4-bit-to-7-segment decoder.
REQ-011 SHALL have port digit_en  output  NUM_DIGITS: one-hot active-high digit enable, or all-zero.
REQ-012 SHALL have port load_ack  output  1: one-cycle pulse when a captured value takes effect.

Function
REQ-013 SHALL implement two states: ACTIVE and GUARD, a slot cycle counter, a digit index idx, a pending register with pending flag, and a shadow register.
REQ-014 SHALL stay in ACTIVE exactly REFRESH_DIV cycles, then enter GUARD with the counter cleared.
REQ-015 SHALL stay in GUARD exactly GUARD_CYCLES cycles, then enter ACTIVE with idx = (idx+1) mod NUM_DIGITS.
REQ-016 SHALL treat the GUARD-to-ACTIVE transition with idx wrapping from NUM_DIGITS-1 to 0 as the frame boundary.
REQ-017 SHALL, on load high, copy value to pending and set pending flag; a later load before the boundary overwrites pending; no load is dropped except by overwrite.
REQ-018 SHALL, at the frame boundary with pending flag set, copy pending to shadow, clear the flag, and assert load_ack for exactly that one cycle.
REQ-019 SHALL, when load is high in the boundary cycle itself, apply that cycle's value directly to shadow and assert load_ack in that same cycle.
REQ-020 SHALL drive nibble = shadow digit idx in every state, with no added latency beyond the state registers.
REQ-021 SHALL drive digit_en = one-hot(idx) in ACTIVE, otherwise all-zero; frame length = NUM_DIGITS*(REFRESH_DIV+GUARD_CYCLES) cycles.
REQ-022 SHALL force digit_en all-zero during the slot of any digit with blank_mask bit set, without changing slot timing.
REQ-023 SHALL, while enable is low, force digit_en all-zero and freeze the counter, state and idx; loads are still captured into pending, and pending is held until the next boundary after enable returns high.
REQ-024 SHALL never assert more than one digit_en bit in any cycle.

Reset
REQ-025 SHALL, on reset, set state GUARD, counter 0, idx NUM_DIGITS-1, shadow 0, pending 0, pending flag 0.
REQ-026 SHALL produce digit_en 0, nibble 0 and load_ack 0 in the first cycle after reset is sampled.
REQ-027 SHALL give reset priority over load and enable, including reset mid-slot.
REQ-028 SHALL begin with the first frame boundary GUARD_CYCLES cycles after reset deasserts, provided enable is high.

Configuration
REQ-029 SHALL provide macro SEG7_LZ_SUPPRESS_EN: when defined, each digit i>0 whose shadow nibble is 0 and all of whose higher digits are 0 SHALL be dark in its slot; digit 0 is always shown.
REQ-030 SHALL, without SEG7_LZ_SUPPRESS_EN, show every unmasked digit including leading zeros, with slot timing identical in both builds.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2)
REQ-031 SHALL cover: reset, then load 0x1234 before the first boundary -> load_ack at the boundary; digit_en 0001 with nibble 4 for 4 cycles, 0000 for 2 cycles, 0010 with nibble 3, and so on; 24-cycle frame.
REQ-032 SHALL cover: load 0xABCD mid-frame -> nibble sequence unchanged until the next boundary; single load_ack there.
REQ-033 SHALL cover: loads of 0x1111 then 0x2222 in the same frame -> shadow becomes 0x2222; exactly one load_ack.
REQ-034 SHALL cover: blank_mask 0100 -> digit 2 slot digit_en 0000; frame still 24 cycles; enable low for 10 cycles -> frame stretches by 10.
REQ-035 SHALL cover: with SEG7_LZ_SUPPRESS_EN, value 0x0040 -> digits 3 and 2 dark, digits 1 and 0 shown; value 0x0000 -> only digit 0 shows 0.
REQ-036 SHALL cover: reset asserted mid-ACTIVE -> next cycle digit_en 0000, nibble 0, shadow 0, pending flag cleared.
